// File: rtl/johnson_pkg.sv
// Shared constants, slot map and segment LUT for the Johnson-code display path.
// Digit codes are thermometer words: value d has bits [d-1:0] set.
package johnson_pkg;

  localparam int CODE_W   = 10;
  localparam int N_DIGITS = 6;
  localparam int IDX_W    = 3;

  typedef logic [IDX_W-1:0] slot_t;

  localparam slot_t SLOT_S0 = 3'd0;
  localparam slot_t SLOT_S1 = 3'd1;
  localparam slot_t SLOT_M0 = 3'd2;
  localparam slot_t SLOT_M1 = 3'd3;
  localparam slot_t SLOT_H0 = 3'd4;
  localparam slot_t SLOT_H1 = 3'd5;

  localparam logic [3:0] SLOT_MAX [N_DIGITS] = '{4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd2};

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } digit_t;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg7_lut(input logic [3:0] value);
    case (value)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/johnson_digit_decode.sv
// Combinational thermometer-code decoder: validity check plus popcount value.
module johnson_digit_decode
  import johnson_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output digit_t            digit
);

  logic [CODE_W-1:0] code_inc;
  logic [3:0]        ones;

  // A thermometer word plus one is a single power of two, so the AND is zero.
  always_comb begin
    code_inc = code + CODE_W'(1);
    ones     = '0;
    for (int i = 0; i < CODE_W; i++) begin
      ones = ones + 4'(code[i]);
    end
    digit.valid = !code[CODE_W-1] && ((code & code_inc) == '0);
    digit.value = ones;
  end

endmodule

// File: rtl/display_johnson_mux.sv
// Six-digit multiplexed seven-segment driver fed by Johnson digit codes.
// Codes are snapshotted once per scan frame; all outputs are registered.
module display_johnson_mux
  import johnson_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CODE_W-1:0]   H_out1_johnson,
  input  logic [CODE_W-1:0]   H_out0_johnson,
  input  logic [CODE_W-1:0]   M_out1_johnson,
  input  logic [CODE_W-1:0]   M_out0_johnson,
  input  logic [CODE_W-1:0]   S_out1_johnson,
  input  logic [CODE_W-1:0]   S_out0_johnson,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] an,
  output logic                code_err
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]    div_p0;
  slot_t               idx_p0;
  logic [CODE_W-1:0]   snap_p0 [N_DIGITS];
  logic [CODE_W-1:0]   code_sel_p0;
  logic [3:0]          max_sel_p0;
  digit_t              digit_p0;
  logic                s0_even_p0;
  logic                div_wrap_p0;
  logic                frame_end_p0;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;
  logic                code_err_nxt;
  logic [N_DIGITS-1:0] an_nxt;

  function automatic logic code_is_even_digit(input logic [CODE_W-1:0] code);
    return !code[CODE_W-1] && ((code & (code + CODE_W'(1))) == '0) && !(^code);
  endfunction

  // ---- stage p0: counters and snapshot select the slot being decoded ----
  assign div_wrap_p0  = (div_p0 == DIV_LAST);
  assign frame_end_p0 = div_wrap_p0 && (idx_p0 == SLOT_H1);
  assign s0_even_p0   = code_is_even_digit(snap_p0[SLOT_S0]);

  always_comb begin
    code_sel_p0 = snap_p0[SLOT_S0];
    max_sel_p0  = SLOT_MAX[SLOT_S0];
    if (idx_p0 <= SLOT_H1) begin
      code_sel_p0 = snap_p0[idx_p0];
      max_sel_p0  = SLOT_MAX[idx_p0];
    end
  end

  johnson_digit_decode u_decode (
    .code  (code_sel_p0),
    .digit (digit_p0)
  );

  always_comb begin
    seg_nxt      = '0;
    code_err_nxt = 1'b0;
    if (!digit_p0.valid || (digit_p0.value > max_sel_p0)) begin
      code_err_nxt = 1'b1;
    end else if (!(LZ_BLANK && (idx_p0 == SLOT_H1) && (digit_p0.value == 4'd0))) begin
      seg_nxt = seg7_lut(digit_p0.value);
    end
    dp_nxt = ((idx_p0 == SLOT_M0) || (idx_p0 == SLOT_H0)) && s0_even_p0;
    an_nxt = ~(N_DIGITS'(1) << idx_p0);
  end

  // ---- stage p1: registered display outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      div_p0   <= '0;
      idx_p0   <= SLOT_S0;
      for (int i = 0; i < N_DIGITS; i++) begin
        snap_p0[i] <= '0;
      end
      seg      <= '0;
      dp       <= 1'b0;
      an       <= '1;
      code_err <= 1'b0;
    end else begin
      div_p0 <= div_wrap_p0 ? '0 : div_p0 + DIV_W'(1);
      if (div_wrap_p0) begin
        idx_p0 <= (idx_p0 == SLOT_H1) ? SLOT_S0 : idx_p0 + IDX_W'(1);
      end
      if (frame_end_p0) begin
        snap_p0[SLOT_S0] <= S_out0_johnson;
        snap_p0[SLOT_S1] <= S_out1_johnson;
        snap_p0[SLOT_M0] <= M_out0_johnson;
        snap_p0[SLOT_M1] <= M_out1_johnson;
        snap_p0[SLOT_H0] <= H_out0_johnson;
        snap_p0[SLOT_H1] <= H_out1_johnson;
      end
      seg      <= seg_nxt;
      dp       <= dp_nxt;
      an       <= an_nxt;
      code_err <= code_err_nxt;
    end
  end

endmodule

// File: doc/display_johnson_mux.md
# display_johnson_mux

Time-multiplexed 6-digit seven-segment driver that consumes the six 10-bit Johnson digit codes produced by the clock core (`relogio_johnson`). It snapshots all six codes once per scan frame and cycles the digit enables. Each code is decoded to 7-segment, with range checking, optional leading-zero blanking and a blinking separator. It sits directly downstream of the clock core and drives the board display pins.

## Interface
- `SCAN_DIV`, default 4: clock cycles each digit is held (≥2).
- `LZ_BLANK`, default 1: when 1, blank the H1 digit when its value is 0.
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `H_out1_johnson` input 10: hours tens code.
- `H_out0_johnson` input 10: hours units code.
- `M_out1_johnson` input 10: minutes tens code.
- `M_out0_johnson` input 10: minutes units code.
- `S_out1_johnson` input 10: seconds tens code.
- `S_out0_johnson` input 10: seconds units code.
- `seg` output 7: active-high segments `{g,f,e,d,c,b,a}`.
- `dp` output 1: active-high decimal point (separator).
- `an` output 6: active-low digit enables; bit i drives digit slot i.
- `code_err` output 1: high while the displayed slot holds an invalid or out-of-range code.

## Operation
- Code format (fixed): digit d (0–9) = 10-bit word with bits [d-1:0]=1 and all other bits 0. So 0 = 10'h000, 1 = 10'h001, 9 = 10'h1FF.
- Any other pattern is invalid, including non-thermometer words and any word with bit 9 set.
- Slot map: 0=S0, 1=S1, 2=M0, 3=M1, 4=H0, 5=H1.
- Per-slot maximum value: S1 ≤5, M1 ≤5, H1 ≤2; all other slots ≤9. A value above the maximum counts as an error.
- Prescaler `div` counts 0..SCAN_DIV-1. When it wraps, slot index `idx` advances 0→1→…→5→0.
- Snapshot: all six inputs are registered together on the edge where `div`=SCAN_DIV-1 and `idx`=5 (frame boundary). Inputs are ignored at all other times, so no tearing within a frame.
- Decode for the current slot:
  - Valid code → `seg` = LUT[value], `code_err`=0.
  - Invalid or out-of-range code → `seg`=0, `code_err`=1.
  - `LZ_BLANK`=1, slot 5, value 0 → `seg`=0, `code_err`=0. The enable still asserts.
- Segment LUT: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F (hex).
- `dp`=1 only in slots 2 and 4, and only when the snapshot S0 value is valid and even. This gives a separator that blinks at 0.5 Hz.
- `an` = ~(1<<idx). Exactly one enable is low at any time outside reset.

## Timing
- Reset values:
  - `div`=0, `idx`=0, all snapshot codes=10'h000.
  - `seg`=0, `dp`=0, `an`=6'b111111, `code_err`=0.
- All outputs are registered and lag the counters by 1 cycle. The first edge with `reset`=0 presents slot 0 of the cleared snapshot: `an`=6'b111110, `seg`=3F.
- Each slot is held for exactly SCAN_DIV cycles; one frame is 6·SCAN_DIV cycles.
- A snapshot taken at edge E is first visible at edge E+1, as slot 0.
- An input change reaches the display at the next frame boundary at the latest, i.e. ≤6·SCAN_DIV+1 cycles.
- Reset mid-frame: the next edge forces reset values. Scanning restarts at slot 0 of the cleared snapshot on the first edge after release.
- Inputs change only on `clk` edges from the same domain; no synchronisers.

## Structure
- Shared package `johnson_pkg` holds:
  - constants `CODE_W`=10 and `N_DIGITS`=6;
  - slot index constants and the per-slot max-value array;
  - function `seg7_lut(value)`.
- One sub-module, `johnson_digit_decode`: combinational, code → {valid, value[3:0]}. Valid = thermometer check; value = popcount.
- The top instantiates one decoder on the slot-selected snapshot code, plus the prescaler, slot counter, snapshot and output registers.

## Test plan
- Reset held 3 cycles → `an`=3F, `seg`=00, `dp`=0, `code_err`=0. After release, first frame with LZ_BLANK=1 shows `seg`=3F in slots 0–4; slot 5 shows `seg`=00 with `an`=6'b011111.
- Inputs held at 15:30:00 codes (H1=001, H0=01F, M1=007, M0=000, S1=000, S0=000):
  - from the second frame: slot 4 `seg`=6D, slot 5 `seg`=06, slot 3 `seg`=4F;
  - `dp`=1 in slots 2 and 4;
  - each slot held 4 cycles.
- Change M0 from 000 to 001 at mid-frame (`idx`=2) → slot 2 stays 3F for the rest of that frame and shows 06 in the next frame.
- Invalid code M0=10'h005 → slot 2 `seg`=00, `code_err`=1. `code_err`=0 in all other slots.
- Out-of-range S1=10'h03F (6) → slot 1 `seg`=00, `code_err`=1.
- S0=001 (odd) → `dp`=0 everywhere. Assert reset at `idx`=3: next edge gives `an`=3F; after release, slot 0 is held 4 cycles.
